// File: rtl/pmem_line_responder_pkg.sv
// pmem_line_responder_pkg
//   Shared memory-interface definitions for the line responder: the
//   rv32i_word address type, line/beat geometry constants, the responder
//   state enum and a line-alignment helper.
//   No ports (package).
package pmem_line_responder_pkg;

  typedef logic [31:0] rv32i_word;

  localparam int S_OFFSET       = 5;
  localparam int S_LINE         = 256;
  localparam int S_BEAT         = 64;
  localparam int BEATS_PER_LINE = S_LINE / S_BEAT;
  localparam int BEAT_IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } pmem_resp_state_t;

  // Clears the byte-offset-within-line bits so every burst starts on a line boundary.
  function automatic rv32i_word align_line(input rv32i_word addr);
    rv32i_word aligned;
    aligned = addr;
    aligned[S_OFFSET-1:0] = '0;
    return aligned;
  endfunction

endpackage

// File: rtl/pmem_line_responder_beat_buffer.sv
// line_beat_buffer
//   Four 64-bit beat slots forming one cache line. A whole line can be
//   loaded at once (write disassembly source) or a single beat written by
//   index (read assembly). The slot selected by beat_idx is always visible
//   on beat_out. Cleared by reset.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load, load_line  load all four slots from a full line
//   beat_we, beat_in write one slot (beat_idx) with beat_in
//   beat_idx         slot index for write and for beat_out
//   beat_out         currently indexed slot
//   line_out         all slots concatenated, slot 0 in bits 63:0
module line_beat_buffer
  import pmem_line_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [S_LINE-1:0]     load_line,
  input  logic                  beat_we,
  input  logic [BEAT_IDX_W-1:0] beat_idx,
  input  logic [S_BEAT-1:0]     beat_in,
  output logic [S_BEAT-1:0]     beat_out,
  output logic [S_LINE-1:0]     line_out
);

  logic [BEATS_PER_LINE-1:0][S_BEAT-1:0] slots;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
    end else if (load) begin
      slots <= load_line;
    end else if (beat_we) begin
      slots[beat_idx] <= beat_in;
    end
  end

  assign beat_out = slots[beat_idx];
  assign line_out = slots;

endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder
//   Services one 256-bit line read or write as a 4-beat 64-bit burst on the
//   physical memory bus, then pulses line_resp for one cycle.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   line_read, line_write        line requests, held until line_resp
//   line_address, line_wdata     request address / write line
//   line_rdata, line_resp        assembled read line / completion pulse
//   burst_read, burst_write      burst commands to memory
//   burst_address, burst_wdata   line-aligned address / current write beat
//   burst_rdata, burst_resp      read beat / per-beat handshake from memory
module pmem_line_responder
  import pmem_line_responder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_read,
  input  logic              line_write,
  input  rv32i_word         line_address,
  input  logic [S_LINE-1:0] line_wdata,
  output logic [S_LINE-1:0] line_rdata,
  output logic              line_resp,
  output logic              burst_read,
  output logic              burst_write,
  output rv32i_word         burst_address,
  output logic [S_BEAT-1:0] burst_wdata,
  input  logic [S_BEAT-1:0] burst_rdata,
  input  logic              burst_resp
);

  pmem_resp_state_t state, next_state;
  logic [BEAT_IDX_W-1:0] cnt;
  rv32i_word             addr_q;
  logic [S_LINE-1:0]     rdata_q;

  logic              load_line;
  logic              beat_we;
  logic              last_beat;
  logic [S_BEAT-1:0] buf_beat;
  logic [S_LINE-1:0] buf_line;
  logic [S_LINE-1:0] rd_line;

  line_beat_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (load_line),
    .load_line (line_wdata),
    .beat_we   (beat_we),
    .beat_idx  (cnt),
    .beat_in   (burst_rdata),
    .beat_out  (buf_beat),
    .line_out  (buf_line)
  );

  assign last_beat = burst_resp && (cnt == BEAT_IDX_W'(BEATS_PER_LINE - 1));
  assign load_line = (state == IDLE) && line_write;
  assign beat_we   = (state == RD_BURST) && burst_resp;

  // The final beat is merged directly so line_rdata updates in the same edge
  // that moves to DONE, instead of waiting for the buffer to catch up.
  always_comb begin
    rd_line = buf_line;
    rd_line[S_LINE-1 -: S_BEAT] = burst_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (line_write) begin
          next_state = WR_BURST;
        end else if (line_read) begin
          next_state = RD_BURST;
        end
      end
      RD_BURST: if (last_beat) next_state = DONE;
      WR_BURST: if (last_beat) next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Beats are counted on burst_resp, so stalls simply hold the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_write || line_read) begin
            cnt    <= '0;
            addr_q <= align_line(line_address);
          end
        end
        RD_BURST: begin
          if (burst_resp) cnt <= cnt + 1'b1;
          if (last_beat) rdata_q <= rd_line;
        end
        WR_BURST: begin
          if (burst_resp) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign line_rdata    = rdata_q;
  assign line_resp     = (state == DONE);
  assign burst_read    = (state == RD_BURST);
  assign burst_write   = (state == WR_BURST);
  assign burst_address = addr_q;
  assign burst_wdata   = (state == WR_BURST) ? buf_beat : '0;

endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder
//   Directed self-checking bench for pmem_line_responder. Inputs change and
//   outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_pmem_line_responder;

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int total;
  int bad;

  pmem_line_responder dut (
    .clk           (clk),
    .rst           (rst),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the bench itself.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues a read, returns the four beats of exp_line back to back and checks
  // burst_read, the aligned address, the single resp pulse and the line.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] exp_line,
                          input logic [31:0] exp_addr, input string tag);
    line_read    = 1'b1;
    line_address = addr;
    burst_resp   = 1'b0;
    step();
    total++;
    if (burst_read !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_burst_read: got %b want 1", tag, burst_read);
    end
    total++;
    if (burst_address !== exp_addr) begin
      bad++;
      $display("[TB] FAIL %s_address: got %h want %h", tag, burst_address, exp_addr);
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = exp_line[i*64 +: 64];
      step();
      total++;
      if (line_resp !== (i == 3)) begin
        bad++;
        $display("[TB] FAIL %s_resp_beat%0d: got %b want %b", tag, i, line_resp, (i == 3));
      end
    end
    total++;
    if (line_rdata !== exp_line) begin
      bad++;
      $display("[TB] FAIL %s_rdata: got %h want %h", tag, line_rdata, exp_line);
    end
    total++;
    if (burst_read !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_burst_read_done: got %b want 0", tag, burst_read);
    end
    line_read   = 1'b0;
    burst_resp  = 1'b0;
    burst_rdata = '0;
    step();
    total++;
    if (line_resp !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_resp_single: got %b want 0", tag, line_resp);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = '0;
    line_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    #12;
    total++;
    if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== '0 ||
        burst_address !== '0 || burst_wdata !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h want all 0",
               line_resp, burst_read, burst_write, burst_address, burst_wdata, line_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    run_read(32'h0000_1234,
             {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
             32'h0000_1220, "read");
  endtask

  task automatic test_write_gaps();
    logic [255:0] wline;
    logic [255:0] prev_rdata;
    wline      = {64'hDDDD_0000_DDDD_0004, 64'hCCCC_0000_CCCC_0003,
                  64'hBBBB_0000_BBBB_0002, 64'hAAAA_0000_AAAA_0001};
    prev_rdata = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_write   = 1'b1;
    line_address = 32'h8000_00E0;
    line_wdata   = wline;
    step();
    total++;
    if (burst_write !== 1'b1 || burst_address !== 32'h8000_00E0) begin
      bad++;
      $display("[TB] FAIL write_start: got wr=%b addr=%h want 1 800000e0", burst_write, burst_address);
    end
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 2; g++) begin
        burst_resp = 1'b0;
        total++;
        if (burst_wdata !== wline[i*64 +: 64] || line_resp !== 1'b0) begin
          bad++;
          $display("[TB] FAIL write_hold%0d: got wdata=%h resp=%b want %h 0",
                   i, burst_wdata, line_resp, wline[i*64 +: 64]);
        end
        step();
      end
      burst_resp = 1'b1;
      total++;
      if (burst_wdata !== wline[i*64 +: 64] || burst_write !== 1'b1) begin
        bad++;
        $display("[TB] FAIL write_ack%0d: got wdata=%h wr=%b want %h 1",
                 i, burst_wdata, burst_write, wline[i*64 +: 64]);
      end
      step();
    end
    burst_resp = 1'b0;
    total++;
    if (line_resp !== 1'b1 || burst_write !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_done: got resp=%b wr=%b want 1 0", line_resp, burst_write);
    end
    total++;
    if (line_rdata !== prev_rdata) begin
      bad++;
      $display("[TB] FAIL write_keeps_rdata: got %h want %h", line_rdata, prev_rdata);
    end
    line_write = 1'b0;
    step();
    total++;
    if (line_resp !== 1'b0) begin
      bad++;
      $display("[TB] FAIL write_resp_single: got %b want 0", line_resp);
    end
  endtask

  task automatic test_simultaneous();
    logic [255:0] wline;
    wline        = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                    64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
    line_write   = 1'b1;
    line_read    = 1'b1;
    line_address = 32'h0000_0105;
    line_wdata   = wline;
    step();
    total++;
    if (burst_write !== 1'b1 || burst_read !== 1'b0) begin
      bad++;
      $display("[TB] FAIL both_priority: got wr=%b rd=%b want 1 0", burst_write, burst_read);
    end
    for (int i = 0; i < 4; i++) begin
      burst_resp = 1'b1;
      total++;
      if (burst_wdata !== wline[i*64 +: 64]) begin
        bad++;
        $display("[TB] FAIL both_wdata%0d: got %h want %h", i, burst_wdata, wline[i*64 +: 64]);
      end
      step();
    end
    burst_resp = 1'b0;
    total++;
    if (line_resp !== 1'b1 || burst_read !== 1'b0) begin
      bad++;
      $display("[TB] FAIL both_done: got resp=%b rd=%b want 1 0", line_resp, burst_read);
    end
    line_write = 1'b0;
    step();
    total++;
    if (burst_read !== 1'b0 || line_resp !== 1'b0) begin
      bad++;
      $display("[TB] FAIL both_no_reaccept: got rd=%b resp=%b want 0 0", burst_read, line_resp);
    end
    run_read(32'h0000_0105,
             {64'h0000_0000_0000_00D4, 64'h0000_0000_0000_00D3,
              64'h0000_0000_0000_00D2, 64'h0000_0000_0000_00D1},
             32'h0000_0100, "both_read");
  endtask

  task automatic test_reset_mid_burst();
    line_read    = 1'b1;
    line_address = 32'h0000_2008;
    step();
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = 64'hEEEE_0000_0000_0000 | 64'(i);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== '0 ||
        burst_address !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got resp=%b rd=%b wr=%b addr=%h rdata=%h want all 0",
               line_resp, burst_read, burst_write, burst_address, line_rdata);
    end
    line_read   = 1'b0;
    burst_resp  = 1'b0;
    burst_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    step();
    total++;
    if (line_resp !== 1'b0 || burst_read !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_idle: got resp=%b rd=%b want 0 0", line_resp, burst_read);
    end
    run_read(32'h0000_3040,
             {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
              64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001},
             32'h0000_3040, "midreset_read");
  endtask

  task automatic test_spurious_resp();
    burst_resp  = 1'b1;
    burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({line_resp, burst_read, burst_write} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL spurious_idle%0d: got resp=%b rd=%b wr=%b want 0 0 0",
                 i, line_resp, burst_read, burst_write);
      end
    end
    burst_resp = 1'b0;
    run_read(32'h0000_0FFF,
             {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
              64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001},
             32'h0000_0FE0, "spurious_read");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_burst();
    test_spurious_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Responder end of the cache-line memory interface. Accepts single 256-bit line read/write requests from a cache or arbiter and services each one as a 4-beat, 64-bit burst on the physical memory bus. Sits between the cache/arbiter `pmem_*` side and the burst DRAM model. A line completes with a one-cycle `line_resp`.

## Interface
- `s_offset`, 5: line offset bits; line base address has these bits zeroed.
- `s_line`, 256: line width in bits.
- `s_beat`, 64: burst beat width in bits; beats per line = `s_line/s_beat` (4).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `line_read`, input, 1: line read request; held until `line_resp`.
- `line_write`, input, 1: line write request; held until `line_resp`.
- `line_address`, input, 32 (`rv32i_word`): request address; low `s_offset` bits ignored.
- `line_wdata`, input, `s_line`: write line; stable while `line_write` is high.
- `line_rdata`, output, `s_line`: assembled read line; valid with `line_resp`, held until next read completes.
- `line_resp`, output, 1: one-cycle completion pulse.
- `burst_read`, output, 1: burst read command.
- `burst_write`, output, 1: burst write command.
- `burst_address`, output, 32: line-aligned burst address.
- `burst_wdata`, output, `s_beat`: current write beat.
- `burst_rdata`, input, `s_beat`: read beat, valid when `burst_resp` is high.
- `burst_resp`, input, 1: beat accepted (write) or beat valid (read).

## Operation
- States: `IDLE`, `RD_BURST`, `WR_BURST`, `DONE`.
- `IDLE`:
  - On `line_write`, latch the aligned address and `line_wdata`, clear the beat counter, and go to `WR_BURST`.
  - Otherwise, on `line_read`, latch the aligned address, clear the counter, and go to `RD_BURST`.
  - Write wins if both requests are high.
- `RD_BURST`:
  - `burst_read`=1.
  - Each cycle with `burst_resp`=1 stores `burst_rdata` into beat slot `cnt` (slot 0 is bits 63:0) and increments `cnt`.
  - On the 4th beat (`cnt`=3 with resp), go to `DONE`.
- `WR_BURST`:
  - `burst_write`=1 and `burst_wdata` = latched beat `cnt`.
  - Each `burst_resp` increments `cnt`; on the 4th, go to `DONE`.
- `DONE`: `line_resp`=1 for exactly one cycle, then return to `IDLE` unconditionally. A request still high in `DONE` is not re-accepted in that cycle.
- Beats are counted, not timed: idle gaps (`burst_resp`=0) in mid-burst are legal and stall the counter.
- `burst_resp` in `IDLE` or `DONE` is ignored.
- `cnt` is 2 bits and wraps to 0 after the 4th beat.
- A request dropped mid-burst is a protocol violation. The burst still completes; `line_resp` still pulses.
- `burst_address` = latched address with low 5 bits zero, constant for the whole burst.

## Timing
- Reset values:
  - state=`IDLE`, `cnt`=0, read buffer=0.
  - `line_rdata`=0, `line_resp`=0, `burst_read`=0, `burst_write`=0.
  - `burst_address`=0, `burst_wdata`=0.
- Reset mid-burst: returns to `IDLE` immediately. No `line_resp` is issued, and the partial read line is discarded (buffer cleared).
- Request sampled at edge T0. `burst_read`/`burst_write` are high from T0+1 and stay high through the cycle carrying the 4th `burst_resp`. They are low in `DONE`.
- With back-to-back beats at T1..T4, `line_resp` is high in T5. Minimum request-to-resp latency is 5 cycles; next accept is at T6.
- All outputs are registered state decodes. There is no combinational path from `burst_resp` to `line_resp`.

## Structure
- `rv32i_types` supplies `rv32i_word`.
- Add to a shared memory package: state enum `pmem_resp_state_t`, and constants `BEATS_PER_LINE`=4 and `BEAT_IDX_W`=2.
- One sub-module is natural: `line_beat_buffer`. It is a 4×64 register with indexed beat write (read assembly) and indexed beat select (write disassembly), plus clear on `rst`.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs 0 immediately; state `IDLE`.
- **Read:** `line_read` at 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles →
  - `burst_address`=0x0000_1220.
  - `line_rdata`=0x4444…_3333…_2222…_1111… with `line_resp` 5 cycles after the request edge.
- **Write:** `line_write` at 0x8000_00E0, `line_wdata` beats A,B,C,D, memory acks with 2-cycle gaps between beats →
  - `burst_wdata` presents A,B,C,D, each held until acked.
  - `line_resp` occurs one cycle after the 4th ack.
- **Simultaneous read+write in `IDLE`** → write burst only. A read then starts after `DONE` if `line_read` is still high.
- **Reset mid-burst:** after 2 read beats, pulse `rst`, then issue a new read → no `line_resp` for the aborted request; the new read returns its own 4 beats correctly.
- **Spurious `burst_resp`:** pulse `burst_resp` in `IDLE` → no state change, no `line_resp`.
